// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch FSM encoding and instruction alignment constants
package core_pkg;

    // Fetch FSM state encoding (3-bit)
    localparam logic [2:0] FETCH_IDLE  = 3'd0;
    localparam logic [2:0] FETCH_REQ   = 3'd1;
    localparam logic [2:0] FETCH_HOLD  = 3'd2;
    localparam logic [2:0] FETCH_EXEC  = 3'd3;
    localparam logic [2:0] FETCH_FAULT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = FETCH_IDLE,
        S_REQ   = FETCH_REQ,
        S_HOLD  = FETCH_HOLD,
        S_EXEC  = FETCH_EXEC,
        S_FAULT = FETCH_FAULT
    } fetch_state_t;

    localparam int         INSTR_BYTES = 4;
    // Low PC bits that must be zero for a word-aligned instruction address
    localparam logic [1:0] ALIGN_MASK  = 2'(INSTR_BYTES - 1);

endpackage

// File: rtl/fetch_pc_register.sv
// rtl/fetch_pc_register.sv - program counter, next-PC selection and branch alignment check
//
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset (pc <= RESET_PC)
//   i_load             commit o_pc_next into the PC this cycle
//   i_branch_taken     select i_branch_target instead of pc+4
//   i_branch_target    branch destination
//   o_pc               current PC
//   o_pc_next          candidate next PC (wraps modulo 2^ADDR_WIDTH)
//   o_misaligned       taken branch to a non-word-aligned target
module fetch_pc_register
    import core_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_load,
    input  logic                  i_branch_taken,
    input  logic [ADDR_WIDTH-1:0] i_branch_target,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [ADDR_WIDTH-1:0] o_pc_next,
    output logic                  o_misaligned
);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_seq;

    // Natural truncation of the add gives the required wrap at the top of memory
    assign w_pc_seq     = r_pc + ADDR_WIDTH'(INSTR_BYTES);
    assign o_pc_next    = i_branch_taken ? i_branch_target : w_pc_seq;
    assign o_misaligned = i_branch_taken && ((i_branch_target[1:0] & ALIGN_MASK) != 2'b00);
    assign o_pc         = r_pc;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= o_pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - single-outstanding instruction fetch with controller start handshake
//
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_fetch_en               permit new fetches; low parks in IDLE once the current instruction retires
//   i_active                 controller active flag
//   i_writeback_state        controller writeback strobe
//   i_branch_taken/target    next-PC selection, sampled only on the writeback cycle
//   o_imem_req/o_imem_addr   instruction memory request, held until i_imem_ack
//   i_imem_ack/i_imem_rdata  memory response
//   o_instruction/o_instr_pc held instruction and its PC
//   o_instr_valid            held instruction is live
//   o_start                  begin-instruction request to the controller
//   o_fault                  sticky misaligned-branch fault
module instruction_fetch_unit
    import core_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_fetch_en,
    input  logic                   i_active,
    input  logic                   i_writeback_state,
    input  logic                   i_branch_taken,
    input  logic [ADDR_WIDTH-1:0]  i_branch_target,
    output logic                   o_imem_req,
    output logic [ADDR_WIDTH-1:0]  o_imem_addr,
    input  logic                   i_imem_ack,
    input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
    output logic [INSTR_WIDTH-1:0] o_instruction,
    output logic [ADDR_WIDTH-1:0]  o_instr_pc,
    output logic                   o_instr_valid,
    output logic                   o_start,
    output logic                   o_fault
);

    fetch_state_t r_state, w_state_next;

    logic                   r_imem_req,    w_imem_req_next;
    logic [ADDR_WIDTH-1:0]  r_imem_addr,   w_imem_addr_next;
    logic [INSTR_WIDTH-1:0] r_instruction, w_instruction_next;
    logic [ADDR_WIDTH-1:0]  r_instr_pc,    w_instr_pc_next;
    logic                   r_instr_valid, w_instr_valid_next;
    logic                   r_start,       w_start_next;
    logic                   r_fault,       w_fault_next;

    logic                   w_pc_load;
    logic [ADDR_WIDTH-1:0]  w_pc;
    logic [ADDR_WIDTH-1:0]  w_pc_next;
    logic                   w_misaligned;
    logic                   w_retire;

    fetch_pc_register #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_load          (w_pc_load),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .o_pc            (w_pc),
        .o_pc_next       (w_pc_next),
        .o_misaligned    (w_misaligned)
    );

    assign w_retire = i_writeback_state && i_active;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= RESET_PC;
            r_instruction <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_start       <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_imem_req    <= w_imem_req_next;
            r_imem_addr   <= w_imem_addr_next;
            r_instruction <= w_instruction_next;
            r_instr_pc    <= w_instr_pc_next;
            r_instr_valid <= w_instr_valid_next;
            r_start       <= w_start_next;
            r_fault       <= w_fault_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_imem_req_next    = r_imem_req;
        w_imem_addr_next   = r_imem_addr;
        w_instruction_next = r_instruction;
        w_instr_pc_next    = r_instr_pc;
        w_instr_valid_next = r_instr_valid;
        w_start_next       = r_start;
        w_fault_next       = r_fault;
        w_pc_load          = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (i_fetch_en) begin
                    w_state_next     = S_REQ;
                    w_imem_req_next  = 1'b1;
                    w_imem_addr_next = w_pc;
                end
            end
            S_REQ: begin
                // fetch_en is deliberately not looked at: an issued request always completes
                if (i_imem_ack) begin
                    w_state_next       = S_HOLD;
                    w_instruction_next = i_imem_rdata;
                    w_instr_pc_next    = w_pc;
                    w_instr_valid_next = 1'b1;
                    w_imem_req_next    = 1'b0;
                    w_start_next       = 1'b1;
                end
            end
            S_HOLD: begin
                if (i_active) begin
                    w_state_next = S_EXEC;
                    w_start_next = 1'b0;
                end
            end
            S_EXEC: begin
                if (w_retire) begin
                    w_instr_valid_next = 1'b0;
                    if (w_misaligned) begin
                        w_state_next = S_FAULT;
                        w_fault_next = 1'b1;
                    end else begin
                        w_pc_load = 1'b1;
                        if (i_fetch_en) begin
                            // Issue the next fetch directly from the freshly computed PC
                            w_state_next     = S_REQ;
                            w_imem_req_next  = 1'b1;
                            w_imem_addr_next = w_pc_next;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end
                end
            end
            S_FAULT: begin
                w_imem_req_next = 1'b0;
                w_start_next    = 1'b0;
                w_fault_next    = 1'b1;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = r_imem_addr;
    assign o_instruction = r_instruction;
    assign o_instr_pc    = r_instr_pc;
    assign o_instr_valid = r_instr_valid;
    assign o_start       = r_start;
    assign o_fault       = r_fault;

endmodule
